// File: rtl/rx_bitslip_align.sv
`default_nettype none
// ============================================================================
// Module   : rx_bitslip_align
// Brief    : Word-alignment controller; pulses the divider BIT_SLIP until the
//            deserialized word matches the training pattern.
// Revision : 1.0 - initial release
// ============================================================================
module rx_bitslip_align #(
    parameter int                WORD_W        = 8,
    parameter logic [WORD_W-1:0] TRAIN_PATTERN = 8'h5C,
    parameter int                MATCH_COUNT   = 16,
    parameter int                SLIP_GAP      = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_n,
    input  logic                    align_start,
    input  logic [WORD_W-1:0]       rx_word,
    input  logic                    rx_valid,
    output logic                    bit_slip,
    output logic                    aligned,
    output logic                    align_err,
    output logic                    align_busy,
    output logic [$clog2(WORD_W):0] slip_cnt
);

    localparam int c_cnt_w   = $clog2(WORD_W) + 1;
    localparam int c_match_w = $clog2(MATCH_COUNT + 1);
    localparam int c_gap_w   = $clog2(SLIP_GAP + 1);

    localparam logic [c_cnt_w-1:0]   c_slip_max   = c_cnt_w'(WORD_W - 1);
    localparam logic [c_match_w-1:0] c_match_last = c_match_w'(MATCH_COUNT - 1);
    localparam logic [c_gap_w-1:0]   c_gap_last   = c_gap_w'(SLIP_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SLIP   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_match_w-1:0] r_match;
    logic [c_match_w-1:0] w_match_nxt;
    logic [c_gap_w-1:0]   r_gap;
    logic [c_gap_w-1:0]   w_gap_nxt;
    logic [c_cnt_w-1:0]   w_slip_cnt_nxt;

    // Outputs are decoded from the next state so they change on the same
    // edge as the state they describe.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_match    <= '0;
            r_gap      <= '0;
            slip_cnt   <= '0;
            bit_slip   <= 1'b0;
            aligned    <= 1'b0;
            align_err  <= 1'b0;
            align_busy <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_match    <= w_match_nxt;
            r_gap      <= w_gap_nxt;
            slip_cnt   <= w_slip_cnt_nxt;
            bit_slip   <= (w_state_nxt == ST_SLIP);
            aligned    <= (w_state_nxt == ST_LOCKED);
            align_err  <= (w_state_nxt == ST_FAIL);
            align_busy <= (w_state_nxt == ST_CHECK) || (w_state_nxt == ST_SLIP) ||
                          (w_state_nxt == ST_WAIT);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_match_nxt    = r_match;
        w_gap_nxt      = r_gap;
        w_slip_cnt_nxt = slip_cnt;

        if (align_start) begin
            w_state_nxt    = ST_CHECK;
            w_match_nxt    = '0;
            w_gap_nxt      = '0;
            w_slip_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_CHECK: begin
                    if (rx_valid) begin
                        if (rx_word == TRAIN_PATTERN) begin
                            w_match_nxt = r_match + 1'b1;
                            if (r_match == c_match_last) begin
                                w_state_nxt = ST_LOCKED;
                            end
                        end else if (slip_cnt < c_slip_max) begin
                            w_state_nxt    = ST_SLIP;
                            w_match_nxt    = '0;
                            w_slip_cnt_nxt = slip_cnt + 1'b1;
                        end else begin
                            w_state_nxt = ST_FAIL;
                        end
                    end
                end
                ST_SLIP: begin
                    w_state_nxt = ST_WAIT;
                    w_gap_nxt   = '0;
                end
                // Words arriving while the divider settles are discarded.
                ST_WAIT: begin
                    if (r_gap == c_gap_last) begin
                        w_state_nxt = ST_CHECK;
                        w_match_nxt = '0;
                    end else begin
                        w_gap_nxt = r_gap + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_bitslip_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_bitslip_align
// Brief    : Self-checking bench for rx_bitslip_align with an event-level
//            reference model and a rotating-lane stimulus model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_bitslip_align;

    localparam logic [7:0] PAT = 8'h5C;
    localparam int         MC  = 16;
    localparam int         GAP = 4;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic       rst_n;
    logic       align_start;
    logic       rx_valid;
    logic [7:0] rx_word;
    logic       bit_slip;
    logic       aligned;
    logic       align_err;
    logic       align_busy;
    logic [3:0] slip_cnt;

    rx_bitslip_align #(
        .WORD_W(8), .TRAIN_PATTERN(PAT), .MATCH_COUNT(MC), .SLIP_GAP(GAP)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .align_start(align_start),
        .rx_word(rx_word), .rx_valid(rx_valid), .bit_slip(bit_slip),
        .aligned(aligned), .align_err(align_err), .align_busy(align_busy),
        .slip_cnt(slip_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0 idle, 1 aligning, 2 locked, 3 failed.
    int cyc     = 0;
    int m_mode  = 0;
    int m_run   = 0;
    int m_slips = 0;
    int m_ign   = -1;
    int m_pulse = -1;

    logic [7:0] lane_base = PAT;
    int         lane_mis  = 0;
    int         pulses     = 0;
    int         last_pulse = -1000;
    int         min_gap    = 1000;

    wire [7:0] act = {bit_slip, aligned, align_err, align_busy, slip_cnt};

    function automatic logic [7:0] expv();
        return {m_pulse == cyc, m_mode == 2, m_mode == 3, m_mode == 1, 4'(m_slips)};
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] w, input int k);
        logic [15:0] d;
        d = {w, w} << k;
        return d[15:8];
    endfunction

    function automatic logic [7:0] lane_word();
        return rotl(lane_base, lane_mis);
    endfunction

    task automatic reset_model();
        m_mode = 0; m_run = 0; m_slips = 0; m_ign = -1; m_pulse = -1;
    endtask

    task automatic clear_track();
        pulses = 0; last_pulse = -1000; min_gap = 1000;
    endtask

    task automatic model_edge();
        cyc++;
        if (!rst_n) begin
            reset_model();
        end else if (align_start) begin
            m_mode = 1; m_run = 0; m_slips = 0; m_ign = -1; m_pulse = -1;
        end else if (m_mode == 1 && cyc > m_ign && rx_valid) begin
            if (rx_word == PAT) begin
                m_run++;
                if (m_run == MC) m_mode = 2;
            end else if (m_slips < 7) begin
                m_slips++;
                m_pulse = cyc;
                m_ign   = cyc + 1 + GAP;
                m_run   = 0;
            end else begin
                m_mode = 3;
            end
        end
    endtask

    // Advance one edge; the lane rotates by one bit for each observed pulse.
    task automatic tick();
        @(posedge clk_in);
        model_edge();
        #1;
        if (bit_slip === 1'b1) begin
            pulses++;
            if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
            last_pulse = cyc;
            lane_mis = (lane_mis + 7) % 8;
        end
    endtask

    task automatic drive(input logic st, input logic v, input logic [7:0] w);
        align_start = st; rx_valid = v; rx_word = w;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; align_start = 1'b1; rx_valid = 1'b1; rx_word = PAT;
        reset_model();
        repeat (3) begin
            tick();
            checks++;
            if (act !== expv()) begin errors++; $display("FAIL reset_hold cyc=%0d got=%b exp=%b", cyc, act, expv()); end
        end
        @(negedge clk_in);
        rst_n = 1'b1; align_start = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if (act !== 8'h00) begin errors++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, act, 8'h00); end
        end
    endtask

    task automatic test_aligned();
        int first;
        lane_base = PAT; lane_mis = 0; clear_track(); first = -1;
        drive(1'b1, 1'b1, lane_word());
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b1, lane_word());
            checks++;
            if (act !== expv()) begin errors++; $display("FAIL aligned_run cyc=%0d got=%b exp=%b", cyc, act, expv()); end
            if (aligned === 1'b1 && first < 0) first = k;
        end
        checks++;
        if (first != MC) begin errors++; $display("FAIL aligned_latency got=%0d exp=%0d", first, MC); end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL aligned_no_slip got=%0d exp=0", pulses); end
    endtask

    task automatic test_misaligned();
        lane_base = PAT; lane_mis = 3; clear_track();
        drive(1'b1, 1'b1, lane_word());
        repeat (80) begin
            drive(1'b0, 1'b1, lane_word());
            checks++;
            if (act !== expv()) begin errors++; $display("FAIL mis3_run cyc=%0d got=%b exp=%b", cyc, act, expv()); end
        end
        checks++;
        if (pulses != 3) begin errors++; $display("FAIL mis3_pulses got=%0d exp=3", pulses); end
        checks++;
        if (min_gap < GAP + 2) begin errors++; $display("FAIL mis3_spacing got=%0d exp>=%0d", min_gap, GAP + 2); end
        checks++;
        if (slip_cnt !== 4'd3 || aligned !== 1'b1) begin
            errors++; $display("FAIL mis3_final got cnt=%0d aligned=%b exp cnt=3 aligned=1", slip_cnt, aligned);
        end
    endtask

    task automatic test_never();
        lane_base = 8'hFF; lane_mis = 0; clear_track();
        drive(1'b1, 1'b1, lane_word());
        repeat (80) begin
            drive(1'b0, 1'b1, lane_word());
            checks++;
            if (act !== expv()) begin errors++; $display("FAIL never_run cyc=%0d got=%b exp=%b", cyc, act, expv()); end
        end
        checks++;
        if (pulses != 7) begin errors++; $display("FAIL never_pulses got=%0d exp=7", pulses); end
        checks++;
        if ({align_err, align_busy, slip_cnt} !== {1'b1, 1'b0, 4'd7}) begin
            errors++; $display("FAIL never_final got err=%b busy=%b cnt=%0d exp err=1 busy=0 cnt=7", align_err, align_busy, slip_cnt);
        end
    endtask

    task automatic test_valid_gaps();
        for (int pass = 0; pass < 2; pass++) begin
            lane_base = PAT; lane_mis = 0; clear_track();
            drive(1'b1, 1'b1, PAT);
            repeat (15) drive(1'b0, 1'b1, PAT);
            repeat (10) begin
                drive(1'b0, 1'b0, 8'h00);
                checks++;
                if (act !== expv()) begin errors++; $display("FAIL gaps_idle cyc=%0d got=%b exp=%b", cyc, act, expv()); end
            end
            drive(1'b0, 1'b1, (pass == 0) ? PAT : 8'hA5);
            checks++;
            if (act !== expv()) begin errors++; $display("FAIL gaps_last cyc=%0d got=%b exp=%b", cyc, act, expv()); end
            checks++;
            if ({bit_slip, aligned} !== ((pass == 0) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL gaps_outcome pass=%0d got slip=%b aligned=%b", pass, bit_slip, aligned);
            end
        end
    endtask

    task automatic test_restart();
        int n;
        lane_base = PAT; lane_mis = 0;
        drive(1'b1, 1'b1, PAT);
        repeat (17) drive(1'b0, 1'b1, PAT);
        drive(1'b1, 1'b1, PAT);
        checks++;
        if ({aligned, align_busy} !== 2'b01 || act !== expv()) begin
            errors++; $display("FAIL restart_locked got=%b exp=%b", act, expv());
        end
        repeat (MC) drive(1'b0, 1'b1, PAT);
        checks++;
        if (act !== expv() || aligned !== 1'b1) begin errors++; $display("FAIL restart_relock got=%b exp=%b", act, expv()); end
        // Restart while the slip pulse is high.
        lane_mis = 2;
        drive(1'b1, 1'b1, lane_word());
        n = 0;
        while (bit_slip !== 1'b1 && n < 10) begin drive(1'b0, 1'b1, lane_word()); n++; end
        checks++;
        if (bit_slip !== 1'b1) begin errors++; $display("FAIL restart_slip_timeout got=%b exp=1", bit_slip); end
        drive(1'b1, 1'b1, lane_word());
        checks++;
        if ({bit_slip, slip_cnt} !== 5'b0_0000 || act !== expv()) begin
            errors++; $display("FAIL restart_in_slip got=%b exp=%b", act, expv());
        end
    endtask

    task automatic test_reset_in_wait();
        int n;
        lane_base = PAT; lane_mis = 2;
        drive(1'b1, 1'b1, lane_word());
        n = 0;
        while (bit_slip !== 1'b1 && n < 10) begin drive(1'b0, 1'b1, lane_word()); n++; end
        checks++;
        if (bit_slip !== 1'b1) begin errors++; $display("FAIL rstwait_timeout got=%b exp=1", bit_slip); end
        drive(1'b0, 1'b1, lane_word());
        drive(1'b0, 1'b1, lane_word());
        #2;
        rst_n = 1'b0;
        reset_model();
        #1;
        checks++;
        if (act !== 8'h00) begin errors++; $display("FAIL rstwait_async got=%b exp=%b", act, 8'h00); end
        clear_track();
        drive(1'b0, 1'b1, lane_word());
        drive(1'b0, 1'b1, lane_word());
        @(negedge clk_in);
        rst_n = 1'b1;
        repeat (20) begin
            drive(1'b0, 1'b1, lane_word());
            checks++;
            if (act !== expv()) begin errors++; $display("FAIL rstwait_after cyc=%0d got=%b exp=%b", cyc, act, expv()); end
        end
        checks++;
        if (pulses != 0) begin errors++; $display("FAIL rstwait_pulses got=%0d exp=0", pulses); end
    endtask

    task automatic test_random();
        logic v;
        logic st;
        for (int r = 0; r < 6; r++) begin
            lane_base = PAT; lane_mis = int'($urandom_range(0, 7));
            drive(1'b1, 1'b1, lane_word());
            repeat (250) begin
                v  = ($urandom_range(0, 3) != 0);
                st = ($urandom_range(0, 199) == 0);
                drive(st, v, v ? lane_word() : 8'($urandom));
                checks++;
                if (act !== expv()) begin errors++; $display("FAIL random run=%0d cyc=%0d got=%b exp=%b", r, cyc, act, expv()); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; align_start = 1'b0; rx_valid = 1'b0; rx_word = 8'h00;
        test_reset();
        test_aligned();
        test_misaligned();
        test_never();
        test_valid_gaps();
        test_restart();
        test_reset_in_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rx_bitslip_align.md
# rx_bitslip_align

Word-alignment controller for a source-synchronous receive lane. It sits in the divided-clock domain, downstream of the lane's divide-by-4 clock divider and deserializer. It compares incoming deserialized words against a training pattern and drives the divider's BIT_SLIP input until the word boundary locks. It reports lock, failure, and the number of slips used.

## Interface
- WORD_W, 8: deserialized word width. This is also the number of distinct bit phases.
- TRAIN_PATTERN, 8'h5C: training word expected once aligned.
- MATCH_COUNT, 16: consecutive valid matching words required to declare lock, range 1..255.
- SLIP_GAP, 4: cycles after each BIT_SLIP pulse during which RX_WORD is ignored, range 1..15.

- CLK_IN  in  1  divided lane clock; all logic runs on its rising edge
- RST_N  in  1  asynchronous active-low reset
- ALIGN_START  in  1  single-cycle request to (re)start alignment
- RX_WORD  in  WORD_W  deserialized word
- RX_VALID  in  1  RX_WORD qualifier
- BIT_SLIP  out  1  one-cycle pulse to the divider; shifts the word boundary by one bit
- ALIGNED  out  1  lock achieved
- ALIGN_ERR  out  1  all phases tried without lock
- ALIGN_BUSY  out  1  alignment in progress
- SLIP_CNT  out  $clog2(WORD_W)+1  BIT_SLIP pulses issued since the last start

## Operation
- All outputs are registered. Reset drives every output to 0 and the state to IDLE.
- States:
  - IDLE: waits for ALIGN_START.
  - CHECK: compares words against TRAIN_PATTERN.
  - SLIP: issues the BIT_SLIP pulse.
  - WAIT: holds off for SLIP_GAP cycles.
  - LOCKED: lock achieved.
  - FAIL: no phase locked.
- ALIGN_START has the highest priority and is honoured in every state. It goes to CHECK and clears the match counter, the gap counter, SLIP_CNT, ALIGNED and ALIGN_ERR. In the same edge it drops BIT_SLIP if that is high.
- CHECK, on an edge where RX_VALID=1:
  - RX_WORD == TRAIN_PATTERN: increment the match counter. When it reaches MATCH_COUNT, go to LOCKED.
  - Mismatch with SLIP_CNT < WORD_W-1: go to SLIP, clear the match counter.
  - Mismatch with SLIP_CNT == WORD_W-1: go to FAIL. All WORD_W phases have been tried.
- CHECK with RX_VALID=0: no action. The match run is preserved and the counter does not advance.
- SLIP: BIT_SLIP=1 for exactly one cycle, SLIP_CNT increments, then go to WAIT.
- WAIT: ignores RX_WORD/RX_VALID for SLIP_GAP cycles, then returns to CHECK with the match counter at 0.
- LOCKED: ALIGNED=1. RX_WORD is no longer examined because payload follows training. The state holds until ALIGN_START or reset.
- FAIL: ALIGN_ERR=1, held until ALIGN_START or reset.
- ALIGN_BUSY=1 exactly in CHECK, SLIP and WAIT.
- SLIP_CNT never exceeds WORD_W-1 and never wraps.

## Timing
- Edge numbering: mismatch sampled at edge E0.
  - BIT_SLIP is high from E0 to E1.
  - Words sampled at E1 through E(1+SLIP_GAP) are ignored.
  - The first compared word is sampled at E(2+SLIP_GAP).
  - The minimum spacing between BIT_SLIP rising edges is SLIP_GAP+2 cycles.
- SLIP_CNT updates on the same edge that BIT_SLIP rises.
- ALIGNED rises on the edge that samples the MATCH_COUNT-th matching valid word. Lock latency from ALIGN_START with an already-aligned lane and continuous RX_VALID is MATCH_COUNT+1 edges.
- ALIGN_ERR rises on the edge that samples the mismatch with SLIP_CNT == WORD_W-1. ALIGN_BUSY falls on that same edge.
- ALIGN_START asserted during SLIP: BIT_SLIP falls at the next edge and SLIP_CNT reads 0. The divider phase is not rolled back.
- RST_N assertion clears all outputs immediately (asynchronously), including a BIT_SLIP pulse in progress. Deassertion is synchronised externally.

## Test plan
- Reset: hold RST_N=0 with ALIGN_START=1 -> BIT_SLIP, ALIGNED, ALIGN_ERR, ALIGN_BUSY and SLIP_CNT all 0; state stays IDLE after release with ALIGN_START=0.
- Aligned lane: ALIGN_START, then continuous 8'h5C words -> ALIGNED=1 on the 16th valid word, SLIP_CNT=0, BIT_SLIP never asserted.
- Lane misaligned by 3 bits: bench model rotates the word by one bit per BIT_SLIP. Expect:
  - exactly 3 BIT_SLIP pulses, each one cycle wide and at least 6 cycles apart;
  - SLIP_CNT=3;
  - ALIGNED after 16 further matches.
- Pattern never present (constant 8'hFF): 7 BIT_SLIP pulses, then ALIGN_ERR=1 with SLIP_CNT=7, ALIGN_BUSY=0, no 8th pulse.
- RX_VALID gaps: 15 matches, then 10 cycles with RX_VALID=0 carrying 8'h00, then 1 match -> ALIGNED. Repeat with a mismatch as the 16th valid word -> BIT_SLIP and no lock.
- Restart/reset: ALIGN_START while LOCKED -> ALIGNED=0 next edge and alignment reruns. RST_N low during WAIT -> all outputs 0 at once, no further BIT_SLIP.
